// File: rtl/pcie_interconexion_n_pkg.sv
// Shared types and helpers for the N-destination interconnect.
package pcie_interconexion_n_pkg;

  typedef enum logic [2:0] {
    ST_RESET  = 3'd0,
    ST_INIT   = 3'd1,
    ST_IDLE   = 3'd2,
    ST_ACTIVE = 3'd3,
    ST_ERROR  = 3'd4
  } state_t;

  // Bit positions inside the sticky error vector
  localparam int ERR_MAIN_OVF  = 0;
  localparam int ERR_DEST_BASE = 1;

  function automatic int clog2(input int v);
    int r;
    r = 0;
    while ((1 << r) < v) r++;
    return r;
  endfunction

endpackage

// File: rtl/pcie_interconexion_n_fifo_sync.sv
// Synchronous FIFO with show-ahead head word and occupancy count.
module fifo_sync
  import pcie_interconexion_n_pkg::*;
#(
  parameter int  WORD_SIZE = 6,
  parameter int  MEM_SIZE  = 4,
  localparam int CNT_W     = clog2(MEM_SIZE + 1),
  localparam int AW        = clog2(MEM_SIZE)
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 push,
  input  logic                 pop,
  input  logic [WORD_SIZE-1:0] data_in,
  output logic [WORD_SIZE-1:0] head,
  output logic [CNT_W-1:0]     count
);

  logic [WORD_SIZE-1:0] mem [MEM_SIZE];
  logic [AW-1:0]        wr_ptr;
  logic [AW-1:0]        rd_ptr;
  logic                 wr;
  logic                 rd;

  // A full FIFO still accepts a write when the same cycle frees a slot
  assign rd   = pop && (count != '0);
  assign wr   = push && ((count != CNT_W'(MEM_SIZE)) || rd);
  assign head = mem[rd_ptr];

  // Pointers wrap naturally because MEM_SIZE is a power of two
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (wr) wr_ptr <= wr_ptr + AW'(1);
      if (rd) rd_ptr <= rd_ptr + AW'(1);
      count <= count + CNT_W'(wr) - CNT_W'(rd);
    end
  end

  // Storage array, no reset needed since reads are gated by count
  always_ff @(posedge clk) begin
    if (wr) mem[wr_ptr] <= data_in;
  end

endmodule

// File: rtl/pcie_interconexion_n.sv
// One input FIFO routed by word top bits into N_DEST destination FIFOs,
// with latched thresholds, pause/almost-empty flags and a control FSM.
module pcie_interconexion_n
  import pcie_interconexion_n_pkg::*;
#(
  parameter int  WORD_SIZE = 6,
  parameter int  MEM_SIZE  = 4,
  parameter int  N_DEST    = 2,
  localparam int CNT_W     = clog2(MEM_SIZE + 1),
  localparam int DEST_W    = clog2(N_DEST)
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          init,
  input  logic [CNT_W-1:0]              umbral_full,
  input  logic [CNT_W-1:0]              umbral_empty,
  input  logic [WORD_SIZE-1:0]          data_in,
  input  logic                          push_data_in,
  input  logic [N_DEST-1:0]             pop,
  output logic [N_DEST*WORD_SIZE-1:0]   data_out,
  output logic [N_DEST-1:0]             valid_out,
  output logic [N_DEST-1:0]             almost_empty,
  output logic                          main_pause,
  output logic [N_DEST:0]               errors,
  output logic                          error_out,
  output logic                          active_out,
  output logic                          idle_out
);

  localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(MEM_SIZE);

  state_t               state;
  state_t               state_nx;
  logic [CNT_W-1:0]     uf_q;
  logic [CNT_W-1:0]     ue_q;
  logic [CNT_W-1:0]     uf_nx;
  logic [CNT_W-1:0]     ue_nx;

  logic [WORD_SIZE-1:0] main_head;
  logic [CNT_W-1:0]     main_count;
  logic [CNT_W-1:0]     main_nx;
  logic [WORD_SIZE-1:0] dest_head  [N_DEST];
  logic [CNT_W-1:0]     dest_count [N_DEST];
  logic [CNT_W-1:0]     dest_nx    [N_DEST];

  logic                 run;
  logic                 push_acc;
  logic                 ovf;
  logic                 fwd;
  logic                 all_empty;
  logic [DEST_W-1:0]    head_dest;
  logic [N_DEST-1:0]    dest_push;
  logic [N_DEST-1:0]    pop_acc;
  logic [N_DEST-1:0]    unf;
  logic [N_DEST:0]      err_set;

  fifo_sync #(.WORD_SIZE(WORD_SIZE), .MEM_SIZE(MEM_SIZE)) u_main (
    .clk     (clk),
    .reset   (reset),
    .push    (push_acc),
    .pop     (fwd),
    .data_in (data_in),
    .head    (main_head),
    .count   (main_count)
  );

  for (genvar g = 0; g < N_DEST; g++) begin : g_dest
    fifo_sync #(.WORD_SIZE(WORD_SIZE), .MEM_SIZE(MEM_SIZE)) u_dest (
      .clk     (clk),
      .reset   (reset),
      .push    (dest_push[g]),
      .pop     (pop_acc[g]),
      .data_in (main_head),
      .head    (dest_head[g]),
      .count   (dest_count[g])
    );
  end

  // Router: accept/drop pushes, head-of-line forwarding, pop qualification
  always_comb begin
    run       = (state == ST_IDLE) || (state == ST_ACTIVE);
    push_acc  = run && push_data_in && (main_count != FULL_CNT);
    ovf       = run && push_data_in && (main_count == FULL_CNT);
    head_dest = main_head[WORD_SIZE-1 -: DEST_W];
    // Destination full check guards thresholds programmed above MEM_SIZE
    fwd       = run && (main_count != '0) &&
                (dest_count[head_dest] < uf_q) &&
                (dest_count[head_dest] != FULL_CNT);
    all_empty = (main_count == '0);
    err_set   = '0;
    err_set[ERR_MAIN_OVF] = ovf;
    for (int i = 0; i < N_DEST; i++) begin
      dest_push[i] = fwd && (head_dest == DEST_W'(i));
      pop_acc[i]   = run && pop[i] && (dest_count[i] != '0);
      unf[i]       = run && pop[i] && (dest_count[i] == '0);
      err_set[ERR_DEST_BASE + i] = unf[i];
      all_empty    = all_empty && (dest_count[i] == '0);
      dest_nx[i]   = dest_count[i] + CNT_W'(dest_push[i]) - CNT_W'(pop_acc[i]);
    end
    main_nx = main_count + CNT_W'(push_acc) - CNT_W'(fwd);
    uf_nx   = (state == ST_INIT) ? umbral_full  : uf_q;
    ue_nx   = (state == ST_INIT) ? umbral_empty : ue_q;
  end

  // FSM state register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= ST_RESET;
    else       state <= state_nx;
  end

  // FSM next state; errors take priority over every other transition
  always_comb begin
    state_nx = state;
    case (state)
      ST_RESET:  state_nx = ST_INIT;
      ST_INIT:   if (!init) state_nx = ST_IDLE;
      ST_IDLE: begin
        if (|err_set)     state_nx = ST_ERROR;
        else if (init)    state_nx = ST_INIT;
        else if (push_acc) state_nx = ST_ACTIVE;
      end
      ST_ACTIVE: begin
        if (|err_set)                       state_nx = ST_ERROR;
        else if (all_empty && !push_data_in) state_nx = ST_IDLE;
      end
      ST_ERROR:  state_nx = ST_ERROR;
      default:   state_nx = ST_RESET;
    endcase
  end

  assign idle_out   = (state == ST_IDLE);
  assign active_out = (state == ST_ACTIVE);
  assign error_out  = (state == ST_ERROR);

  // Thresholds, read data, flags from post-update counts, sticky errors
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      uf_q         <= '0;
      ue_q         <= '0;
      data_out     <= '0;
      valid_out    <= '0;
      main_pause   <= 1'b0;
      almost_empty <= '1;
      errors       <= '0;
    end else begin
      uf_q       <= uf_nx;
      ue_q       <= ue_nx;
      valid_out  <= pop_acc;
      main_pause <= (main_nx >= uf_nx);
      for (int i = 0; i < N_DEST; i++) begin
        if (pop_acc[i]) data_out[i*WORD_SIZE +: WORD_SIZE] <= dest_head[i];
        almost_empty[i] <= (dest_nx[i] <= ue_nx);
      end
      errors <= errors | err_set;
    end
  end

endmodule
